// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-locked sharing of one FIFO write port among NUM_REQ producers.
// Also owns the FIFO full threshold and defers threshold changes until the FIFO is idle and empty.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int DEPTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [5:0]                cfg_tresh_in,
  input  logic                      cfg_tresh_load,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      fifo_write_enable,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [5:0]                fifo_full_tresh,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      cfg_pending
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [1:0] last_grant, win;
  logic [3:0] beat_cnt;
  logic [5:0] pend, clamped;
  logic any, beat, last_beat, start, apply;
  assign any       = |req_valid;
  assign start     = state == IDLE && any;
  assign beat      = state == GRANT && req_valid[grant_id] && !fifo_full;
  assign last_beat = beat && beat_cnt == 4'(MAX_BURST - 1);
  // Threshold may only move while nothing can be written, so it never drops below occupancy.
  assign apply     = state == IDLE && fifo_empty && !any && cfg_pending;
  assign clamped   = cfg_tresh_in == '0 ? 6'd1 : cfg_tresh_in > 6'(DEPTH) ? 6'(DEPTH) : cfg_tresh_in;
  // Descending scan so the smallest offset from last_grant is the final assignment.
  always_comb begin
    win = last_grant;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[2'(last_grant + 2'(k))]) win = 2'(last_grant + 2'(k));
  end
  always_ff @(posedge clock)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (any ? GRANT : IDLE)
             : (last_beat || !req_valid[grant_id]) ? IDLE : GRANT;
  end
  always_comb begin
    busy              = state == GRANT;
    req_ready         = (busy && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
    fifo_write_enable = busy && req_valid[grant_id] && !fifo_full;
    fifo_data_in      = busy ? req_data[grant_id*DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      grant_id        <= '0;
      beat_cnt        <= '0;
      last_grant      <= 2'(NUM_REQ - 1);
      fifo_full_tresh <= 6'(DEPTH);
      pend            <= 6'(DEPTH);
      cfg_pending     <= 1'b0;
    end else begin
      if (start) begin
        grant_id <= win;
        beat_cnt <= '0;
      end else if (beat) beat_cnt <= beat_cnt + 4'd1;
      if (state == GRANT && state_nx == IDLE) last_grant <= grant_id;
      if (apply) fifo_full_tresh <= pend;
      if (cfg_tresh_load) begin
        pend        <= clamped;
        cfg_pending <= 1'b1;
      end else if (apply) cfg_pending <= 1'b0;
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized producers against a grant/burst reference model with scoreboard queues.
module tb_fifo_write_arbiter;
  localparam int N = 4, W = 8, MB = 4, D = 32;
  logic clock = 0, reset_n = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [5:0] cfg_tresh_in = '0, fifo_full_tresh;
  logic cfg_tresh_load = 0, fifo_full = 0, fifo_empty = 0;
  logic fifo_write_enable, busy, cfg_pending;
  logic [W-1:0] fifo_data_in;
  logic [1:0] grant_id;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cfg_tresh_in(cfg_tresh_in), .cfg_tresh_load(cfg_tresh_load),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_write_enable(fifo_write_enable),
    .fifo_data_in(fifo_data_in), .fifo_full_tresh(fifo_full_tresh), .grant_id(grant_id),
    .busy(busy), .cfg_pending(cfg_pending));

  always #5 clock = ~clock;

  typedef struct packed {logic busy; logic [1:0] gid; logic [3:0] rdy; logic [5:0] tresh; logic pend;} st_t;
  typedef struct packed {logic [1:0] gid; logic [7:0] data;} wr_t;
  st_t st_q[$];
  wr_t wr_q[$];
  int checks = 0, fails = 0;

  int owner = -1, cnt = 0, last = N - 1, m_gid = 0, m_tresh = D, m_pend_v = D;
  bit m_pend = 0;
  logic [7:0] head[N];
  int budget[N];
  bit held[N];
  int p_valid, p_full, p_empty, p_load, p_rst;
  logic [3:0] mask;

  function automatic int clamp(int t);
    return t == 0 ? 1 : (t > D ? D : t);
  endfunction

  task automatic model_reset();
    owner = -1; cnt = 0; last = N - 1; m_gid = 0; m_tresh = D; m_pend = 0;
  endtask

  // One clock cycle: drive inputs, push expected outputs, advance the model, step to next edge.
  task automatic cycle();
    st_t s;
    logic [3:0] v;
    bit apply, rst, found;
    int g, idx, r;
    for (int i = 0; i < N; i++)
      if (!held[i] && mask[i] && budget[i] != 0 && $urandom_range(99) < p_valid) held[i] = 1;
    rst = $urandom_range(999) < p_rst;
    for (int i = 0; i < N; i++) begin
      v[i] = held[i] && !rst;
      req_data[i*W +: W] = head[i];
    end
    req_valid = v;
    reset_n = !rst;
    fifo_full = $urandom_range(99) < p_full;
    fifo_empty = $urandom_range(99) < p_empty;
    cfg_tresh_load = $urandom_range(99) < p_load;
    r = $urandom_range(3);
    cfg_tresh_in = r == 0 ? 6'd0 : r == 1 ? 6'd40 : 6'($urandom_range(63));
    s.busy = owner >= 0;
    s.gid = 2'(m_gid);
    s.rdy = (owner >= 0 && !fifo_full) ? 4'(1 << owner) : 4'd0;
    s.tresh = 6'(m_tresh);
    s.pend = m_pend;
    st_q.push_back(s);
    apply = owner < 0 && fifo_empty && v == 0 && m_pend;
    if (owner >= 0) begin
      g = owner;
      if (v[g] && !fifo_full) begin
        wr_q.push_back('{gid: 2'(g), data: head[g]});
        held[g] = 0;
        head[g] = head[g] + 8'd1;
        if (budget[g] > 0) budget[g]--;
        cnt++;
      end
      if (!v[g] || cnt == MB) begin last = g; owner = -1; end
    end else if (v != 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (last + k) % N;
        if (!found && v[idx]) begin owner = idx; found = 1; end
      end
      m_gid = owner;
      cnt = 0;
    end
    if (apply) m_tresh = m_pend_v;
    if (cfg_tresh_load) begin m_pend_v = clamp(int'(cfg_tresh_in)); m_pend = 1; end
    else if (apply) m_pend = 0;
    if (rst) model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic phase(logic [3:0] m, int pv, int pf, int pe, int pl, int pr, int n);
    mask = m; p_valid = pv; p_full = pf; p_empty = pe; p_load = pl; p_rst = pr;
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(negedge clock) begin
    if (st_q.size() > 0) begin
      st_t e;
      e = st_q.pop_front();
      checks++;
      if ({busy, grant_id, req_ready, fifo_full_tresh, cfg_pending} !== e) begin
        fails++;
        $display("FAIL status @%0t: got busy=%b gid=%0d rdy=%b tresh=%0d pend=%b, expected busy=%b gid=%0d rdy=%b tresh=%0d pend=%b",
                 $time, busy, grant_id, req_ready, fifo_full_tresh, cfg_pending, e.busy, e.gid, e.rdy, e.tresh, e.pend);
      end
      if (fifo_write_enable !== 1'b0) begin
        checks++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL write @%0t: got unexpected write we=%b data=%h, expected none", $time, fifo_write_enable, fifo_data_in);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (fifo_write_enable !== 1'b1 || {grant_id, fifo_data_in} !== w) begin
            fails++;
            $display("FAIL write @%0t: got gid=%0d data=%h, expected gid=%0d data=%h", $time, grant_id, fifo_data_in, w.gid, w.data);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin head[i] = 8'(i * 64); budget[i] = 0; held[i] = 0; end
    head[0] = 8'hA0;
    budget[0] = 6;
    mask = '0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    phase(4'b0001, 100, 0, 0, 0, 0, 14);
    for (int i = 0; i < N; i++) budget[i] = -1;
    phase(4'b1111, 100, 0, 0, 0, 0, 60);
    phase(4'b0100, 100, 40, 0, 0, 0, 60);
    phase(4'b1111, 100, 35, 30, 5, 0, 300);
    phase(4'b1011, 60, 15, 60, 10, 0, 400);
    phase(4'b1111, 50, 20, 50, 10, 15, 1200);
    phase(4'b0000, 0, 0, 100, 0, 0, 6);
    checks++;
    if (wr_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d unconsumed expected writes, expected 0", wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
